// File: rtl/pooling_pkg.sv
// Shared constants, index widths and types for the pooling layer controller.
// The tag pipeline and the top-level sequencer both import this package.
package pooling_pkg;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int INPUT_SIZE    = 6;
   localparam int KERNEL_SIZE   = 2;
   localparam int OUTPUT_SIZE   = INPUT_SIZE / KERNEL_SIZE;
   localparam int NUM_CHANNEL   = 6;
   localparam int ARRAY_LATENCY = 2;

   localparam int WIN_W    = idx_w(KERNEL_SIZE);
   localparam int IN_ROW_W = idx_w(INPUT_SIZE);
   localparam int ROW_W    = idx_w(OUTPUT_SIZE);
   localparam int CHAN_W   = idx_w(NUM_CHANNEL);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} pool_state_t;

   typedef struct packed {
      logic              valid;
      logic [ROW_W-1:0]  row;
      logic [CHAN_W-1:0] chan;
   } pool_tag_t;

endpackage

// File: rtl/pooling_tag_pipe.sv
// Delay line that carries the {row, channel} tag of each completed window so it
// emerges alongside the pooled result at the array output.
module pooling_tag_pipe
   import pooling_pkg::*;
#(
   parameter int DEPTH = ARRAY_LATENCY
)(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush,
   input  logic      push,
   input  pool_tag_t push_tag,
   output pool_tag_t tail,
   output logic      any_valid
);

   pool_tag_t stage_q [DEPTH];
   pool_tag_t stage_d [DEPTH];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      stage_d[0] = push ? push_tag : '0;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
      end
   end

   // Entries that have not yet reached the tail; once this is clear the last
   // tag is either on the output now or already gone.
   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) any_valid = any_valid | stage_q[i].valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the stages are reset (not left uninitialised like a RAM) because their valid bits gate out_valid.
      if (!rst_n) begin
         stage_q <= '{default: '0};
      end else begin
         // NOTE: state updates use non-blocking assignment so every stage samples the pre-edge values.
         stage_q <= stage_d;
      end
   end

   assign tail = stage_q[DEPTH-1];

endmodule

// File: rtl/pooling_layer_ctrl.sv
// Sequencer for the pooling datapath: steps the input cache row select, strobes
// the pooling array per window and tags pooled rows with row/channel indices.
module pooling_layer_ctrl
   import pooling_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              kernel_calc_fin,
   output logic              cache_en,
   output logic [WIN_W-1:0]  cache_sel,
   output logic              array_clear,
   output logic              array_accum,
   output logic              out_valid,
   output logic [ROW_W-1:0]  out_row,
   output logic [CHAN_W-1:0] out_chan,
   output logic              map_done,
   output logic              frame_done,
   output logic              busy,
   output logic              err_short
);

   pool_state_t         state_q, state_d;
   logic [WIN_W-1:0]    win_row_q, win_row_d;
   logic [IN_ROW_W-1:0] in_row_q, in_row_d;
   logic [ROW_W-1:0]    out_row_nxt_q, out_row_nxt_d;
   logic [CHAN_W-1:0]   chan_q, chan_d;
   logic                array_clear_q, array_clear_d;
   logic                array_accum_q, array_accum_d;
   logic                map_done_q, map_done_d;
   logic                frame_done_q, frame_done_d;
   logic                err_short_q, err_short_d;

   logic      accept, last_row, win_last, early_fin;
   logic      push, pipe_flush, any_valid;
   pool_tag_t push_tag, tail;

   assign in_ready  = (state_q == RUN);
   assign accept    = in_valid & in_ready;
   assign last_row  = (in_row_q == IN_ROW_W'(INPUT_SIZE - 1));
   assign win_last  = (win_row_q == WIN_W'(KERNEL_SIZE - 1));
   assign early_fin = accept & kernel_calc_fin & ~last_row;

   always_comb begin
      state_d       = state_q;
      win_row_d     = win_row_q;
      in_row_d      = in_row_q;
      out_row_nxt_d = out_row_nxt_q;
      chan_d        = chan_q;
      array_clear_d = accept & (win_row_q == '0);
      array_accum_d = accept;
      map_done_d    = 1'b0;
      frame_done_d  = 1'b0;
      err_short_d   = err_short_q;
      push          = 1'b0;
      pipe_flush    = 1'b0;
      push_tag      = '{valid: 1'b1, row: out_row_nxt_q, chan: chan_q};

      if (abort) begin
         state_d       = IDLE;
         win_row_d     = '0;
         in_row_d      = '0;
         out_row_nxt_d = '0;
         chan_d        = '0;
         array_clear_d = 1'b0;
         array_accum_d = 1'b0;
         pipe_flush    = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d       = RUN;
                  win_row_d     = '0;
                  in_row_d      = '0;
                  out_row_nxt_d = '0;
                  chan_d        = '0;
                  err_short_d   = 1'b0;
               end
            end
            RUN: begin
               if (early_fin) begin
                  // Partial window is dropped: no tag is pushed for it.
                  err_short_d = 1'b1;
                  state_d     = FLUSH;
               end else if (accept) begin
                  win_row_d = win_last ? '0 : win_row_q + 1'b1;
                  in_row_d  = last_row ? in_row_q : in_row_q + 1'b1;
                  if (win_last) begin
                     push          = 1'b1;
                     out_row_nxt_d = (out_row_nxt_q == ROW_W'(OUTPUT_SIZE - 1)) ?
                                     '0 : out_row_nxt_q + 1'b1;
                  end
                  if (last_row || kernel_calc_fin) state_d = FLUSH;
               end
            end
            FLUSH: begin
               if (!any_valid) begin
                  state_d      = DONE;
                  map_done_d   = 1'b1;
                  frame_done_d = (chan_q == CHAN_W'(NUM_CHANNEL - 1));
               end
            end
            DONE: begin
               win_row_d     = '0;
               in_row_d      = '0;
               out_row_nxt_d = '0;
               if (chan_q == CHAN_W'(NUM_CHANNEL - 1)) begin
                  state_d = IDLE;
                  chan_d  = '0;
               end else begin
                  state_d = RUN;
                  chan_d  = chan_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         win_row_q     <= '0;
         in_row_q      <= '0;
         out_row_nxt_q <= '0;
         chan_q        <= '0;
         array_clear_q <= 1'b0;
         array_accum_q <= 1'b0;
         map_done_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         err_short_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         win_row_q     <= win_row_d;
         in_row_q      <= in_row_d;
         out_row_nxt_q <= out_row_nxt_d;
         chan_q        <= chan_d;
         array_clear_q <= array_clear_d;
         array_accum_q <= array_accum_d;
         map_done_q    <= map_done_d;
         frame_done_q  <= frame_done_d;
         err_short_q   <= err_short_d;
      end
   end

   pooling_tag_pipe #(.DEPTH(ARRAY_LATENCY)) u_tag_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (pipe_flush),
      .push      (push),
      .push_tag  (push_tag),
      .tail      (tail),
      .any_valid (any_valid)
   );

   assign cache_en    = accept;
   assign cache_sel   = win_row_q;
   assign array_clear = array_clear_q;
   assign array_accum = array_accum_q;
   assign out_valid   = tail.valid;
   assign out_row     = tail.row;
   assign out_chan    = tail.chan;
   assign map_done    = map_done_q;
   assign frame_done  = frame_done_q;
   assign busy        = (state_q != IDLE);
   assign err_short   = err_short_q;

endmodule
